// File: rtl/divide_three_serial_tx.sv
// Parallel-to-serial MSB-first transmitter with an optional running mod-3 reference
// remainder of the whole stream, built when DIVIDE_THREE_TX_MOD3_REF_EN is defined.
module divide_three_serial_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  data_out,
    output logic                  valid_out,
    output logic                  done,
    output logic                  busy,
    output logic [1:0]            rem_out,
    output logic                  exp_detect
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAPM1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t                r_state, w_state_nx;
    logic [DATA_WIDTH-1:0] r_sr, w_sr_nx;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
    logic [3:0]            r_gap, w_gap_nx;
    logic                  r_din_ready, r_data, r_valid, r_done, r_busy;

    always_comb begin
        w_state_nx = r_state;
        w_sr_nx    = r_sr;
        w_cnt_nx   = r_cnt;
        w_gap_nx   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (din_valid && r_din_ready) begin
                    w_state_nx = S_SHIFT;
                    w_sr_nx    = din;
                    w_cnt_nx   = CNT_W'(DATA_WIDTH - 1);
                end
            end
            S_SHIFT: begin
                w_sr_nx  = {r_sr[DATA_WIDTH-2:0], 1'b0};
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nx = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nx = S_GAP;
                        w_gap_nx   = 4'(GAPM1);
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == 4'd0) w_state_nx = S_IDLE;
                else               w_gap_nx   = r_gap - 4'd1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_din_ready <= 1'b0;
            r_data      <= 1'b0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sr        <= w_sr_nx;
            r_cnt       <= w_cnt_nx;
            r_gap       <= w_gap_nx;
            r_din_ready <= (w_state_nx == S_IDLE);
            r_valid     <= (w_state_nx == S_SHIFT);
            r_data      <= (w_state_nx == S_SHIFT) & w_sr_nx[DATA_WIDTH-1];
            r_done      <= (w_state_nx == S_SHIFT) && (w_cnt_nx == '0);
            r_busy      <= (w_state_nx != S_IDLE);
        end
    end

    assign din_ready = r_din_ready;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign done      = r_done;
    assign busy      = r_busy;

`ifdef DIVIDE_THREE_TX_MOD3_REF_EN
    logic [1:0] r_rem, w_rem_nx;
    logic       r_exp;

    // rem' = (2*rem + bit) mod 3 as a lookup; the encoding 3 never occurs.
    always_comb begin
        w_rem_nx = 2'd0;
        case ({r_rem, r_data})
            3'b000: w_rem_nx = 2'd0;
            3'b001: w_rem_nx = 2'd1;
            3'b010: w_rem_nx = 2'd2;
            3'b011: w_rem_nx = 2'd0;
            3'b100: w_rem_nx = 2'd1;
            3'b101: w_rem_nx = 2'd2;
            default: w_rem_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 2'd0;
            r_exp <= 1'b0;
        end else if (r_valid) begin
            r_rem <= w_rem_nx;
            r_exp <= (w_rem_nx == 2'd0);
        end
    end

    assign rem_out    = r_rem;
    assign exp_detect = r_exp;
`else
    assign rem_out    = 2'b00;
    assign exp_detect = 1'b0;
`endif

endmodule

// File: tb/tb_divide_three_serial_tx.sv
// Directed + randomized bench for divide_three_serial_tx; the stream remainder is
// modelled as the integer value of all sent words taken mod 3.
module tb_divide_three_serial_tx;
    localparam int DW  = 8;
    localparam int GAP = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready, data_out, valid_out, done, busy, exp_detect;
    logic [1:0]    rem_out;

    int vectors = 0;
    int miscompares = 0;
    int m_rem = 0;       // stream value mod 3 after all completed words
    bit m_seen = 1'b0;   // at least one bit has been sent since reset

`ifdef DIVIDE_THREE_TX_MOD3_REF_EN
    localparam bit REF_ON = 1'b1;
`else
    localparam bit REF_ON = 1'b0;
`endif

    divide_three_serial_tx #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .data_out(data_out), .valid_out(valid_out),
        .done(done), .busy(busy), .rem_out(rem_out), .exp_detect(exp_detect)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remainder of the stream after the first nbits bits of word w have been appended.
    function automatic int prefix_rem(input int start, input logic [DW-1:0] w, input int nbits);
        int v;
        v = start;
        for (int j = 0; j < nbits; j++) v = (v * 2) % 3;
        return (v + (int'(w) >> (DW - nbits))) % 3;
    endfunction

    task automatic send_word(input logic [DW-1:0] w, input bit hold, input int abort_at);
        int n;
        int r;
        n = 0;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", din_ready, 1);
        din = w;
        din_valid = 1'b1;
        @(negedge clk);
        if (!hold) din_valid = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (hold) din = DW'($urandom);
            r = prefix_rem(m_rem, w, i);
            chk("valid", valid_out, 1);
            chk("data", data_out, w[DW-1-i]);
            chk("done", done, (i == DW - 1));
            chk("ready_low", din_ready, 0);
            chk("rem_mid", rem_out, REF_ON ? r : 0);
            chk("exp_mid", exp_detect, REF_ON && (i == 0 ? m_seen : 1'b1) && (r == 0));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", valid_out, 0);
                chk("rst_rem", rem_out, 0);
                chk("rst_busy", busy, 0);
                m_rem = 0;
                m_seen = 1'b0;
                din_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        m_rem = (m_rem * (1 << DW) + int'(w)) % 3;
        m_seen = 1'b1;
        chk("rem_word", rem_out, REF_ON ? m_rem : 0);
        chk("exp_word", exp_detect, REF_ON && (m_rem == 0));
        for (int g = 0; g < GAP; g++) begin
            if (hold) din = DW'($urandom);
            chk("gap_valid", valid_out, 0);
            chk("gap_data", data_out, 0);
            chk("gap_ready", din_ready, 0);
            @(negedge clk);
        end
        chk("ready_back", din_ready, 1);
        chk("idle_valid", valid_out, 0);
        chk("idle_busy", busy, 0);
        din_valid = 1'b0;
    endtask

    initial begin
        // reset and ready
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_out", {din_ready, data_out, valid_out, done, busy, rem_out, exp_detect}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", din_ready, 1);
        chk("busy_after_rst", busy, 0);

        // single word, then cross-word accumulation 0x05,0x01 (1281 = 3*427)
        send_word(8'h03, 1'b0, -1);
        send_word(8'h05, 1'b0, -1);
        chk("x05_rem", rem_out, REF_ON ? 2 : 0);
        send_word(8'h01, 1'b0, -1);
        chk("x0501_exp", exp_detect, REF_ON ? 1 : 0);

        // randomized words with din_valid held through SHIFT/GAP
        for (int k = 0; k < 24; k++) send_word(DW'($urandom), 1'b1, -1);

        // reset during bit 4 of 0xFF, then 0x06 alone
        send_word(8'hFF, 1'b0, 3);
        send_word(8'h06, 1'b0, -1);
        chk("after_abort_rem", rem_out, 0);
        chk("after_abort_exp", exp_detect, REF_ON ? 1 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/divide_three_serial_tx.md
# divide_three_serial_tx

Serial bit-stream transmitter feeding the mod-3 divisibility detector. It accepts parallel words through a valid/ready handshake and shifts each word out MSB-first on a one-bit `data_out` line qualified by `valid_out`. It also keeps a running reference remainder of the whole transmitted stream, so benches and on-chip self-test can compare it against the detector's `detect_true`.

## Interface
- `DATA_WIDTH`, default 8: bits per word, must be ≥ 2.
- `GAP_CYCLES`, default 1: idle cycles with `valid_out` low after each word, 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `din`  in  DATA_WIDTH  parallel word to send.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word.
- `data_out`  out  1  serial bit, MSB first.
- `valid_out`  out  1  `data_out` is valid this cycle.
- `done`  out  1  one-cycle pulse coinciding with the last bit of a word.
- `busy`  out  1  state ≠ IDLE.
- `rem_out`  out  2  stream remainder mod 3 (only with `MOD3_REF_EN`).
- `exp_detect`  out  1  `rem_out == 0` and at least one bit sent (only with `MOD3_REF_EN`).

## Operation
- FSM states are IDLE, SHIFT and GAP. All outputs are registered.
- **IDLE:**
  - `din_ready`=1.
  - On a rising edge with `din_valid` && `din_ready`: load the shift register with `din`, load the bit counter with DATA_WIDTH-1, and go to SHIFT.
- **SHIFT:**
  - `valid_out`=1, `data_out`=shift_reg[MSB].
  - Each cycle, shift left by one and decrement the counter.
  - In the cycle where the counter is 0, `done`=1.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - `din_ready`=0 and `din_valid` is ignored.
- **GAP:**
  - `valid_out`=0 and `data_out`=0.
  - Count GAP_CYCLES cycles, then go to IDLE.
- `data_out` is 0 whenever `valid_out` is 0.
- Back-to-back words are impossible: there is at least one non-valid cycle between words, which is the IDLE acceptance cycle.
- **Remainder update:** on each cycle with `valid_out`=1, rem ← (2·rem + `data_out`) mod 3.
  - Computed with a 2-bit lookup. The value 3 is never stored.
  - Words do not reset the remainder. The stream is one continuous number, matching the detector.
  - Only `rst_n` clears it.
- **`din` while not ready:** `din` changes while `din_ready`=0 have no effect.

## Timing
- **Reset values:** `din_ready`=0, `data_out`=0, `valid_out`=0, `done`=0, `busy`=0, `rem_out`=0, `exp_detect`=0, state=IDLE.
- **After reset release:** `din_ready` rises on the first rising edge.
- **Word latency:** if a word is accepted at edge k, bit MSB is valid during cycle k+1 and the last bit during cycle k+DATA_WIDTH.
- **Done pulse:** `done` is high during cycle k+DATA_WIDTH.
- **Next acceptance:** `din_ready` is high again from cycle k+DATA_WIDTH+GAP_CYCLES+1.
- **Remainder timing:** `rem_out` and `exp_detect` update at the edge ending each valid bit cycle. They reflect all bits sent so far, one cycle after the bit.
- **`exp_detect` after reset:** stays 0 until the first valid bit has been consumed, then follows `rem_out == 0`.
- **Reset mid-word:** all registers return to reset values immediately, the partially sent word is discarded, and the remainder is cleared.

## Configuration
- `DIVIDE_THREE_TX_MOD3_REF_EN` defined:
  - The remainder tracker is built.
  - `rem_out` and `exp_detect` behave as above.
- Undefined:
  - The tracker is not built.
  - `rem_out` is tied to 2'b00 and `exp_detect` to 0.
  - All other ports are unchanged.

## Test plan
- **Reset and ready:** hold `rst_n`=0 for 5 cycles, then release.
  - All outputs are 0 during reset.
  - `din_ready`=1 one edge after release.
- **Single word:** DATA_WIDTH=8, GAP_CYCLES=1, send `din`=8'h03.
  - Serial bits are 0,0,0,0,0,0,1,1 on 8 consecutive valid cycles.
  - `done` is high on the 8th bit.
  - `rem_out` sequence is 0,0,0,0,0,0,1,0.
  - `exp_detect`=1 after the last bit.
  - `din_ready` returns after 1 gap cycle.
- **Cross-word accumulation:** send 8'h05 and then 8'h01 (stream value 1281 = 3·427).
  - After the first word: `rem_out`=2, `exp_detect`=0.
  - After the second word: `rem_out`=0, `exp_detect`=1.
- **Handshake:** hold `din_valid`=1 continuously with changing `din`.
  - A word is accepted only in IDLE cycles.
  - No bits from words offered during SHIFT or GAP appear.
  - There is exactly one `valid_out`-low cycle per boundary plus GAP_CYCLES.
- **Reset mid-word:** assert `rst_n` low during bit 4 of 8'hFF.
  - `valid_out` and `rem_out` are cleared immediately.
  - After release, 8'h06 alone yields `rem_out`=0 and `exp_detect`=1.
- **Macro off:** build without `DIVIDE_THREE_TX_MOD3_REF_EN` and send 8'h03.
  - Serial output is identical to the macro-on build.
  - `rem_out`=0 and `exp_detect`=0 throughout.
